// File: rtl/vga_framebuffer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_framebuffer_if
// Description : Bundle of the framebuffer's display-side and host-side signals.
//               Display side: pixel counters in (iCtrH, iCtrV), colour out (data).
//               Host side   : valid/ready cell write (iWrValid, oWrReady, iWrX,
//                             iWrY, iWrColor), clear command (iClear,
//                             iClearColor), status (oBusy, oWrErr).
//               master = pixel/host source, slave = framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_framebuffer_if;
  logic [18:0] iCtrH;
  logic [18:0] iCtrV;
  logic [2:0]  data;
  logic        iWrValid;
  logic        oWrReady;
  logic [6:0]  iWrX;
  logic [5:0]  iWrY;
  logic [2:0]  iWrColor;
  logic        iClear;
  logic [2:0]  iClearColor;
  logic        oBusy;
  logic        oWrErr;

  modport master (
    output iCtrH, iCtrV, iWrValid, iWrX, iWrY, iWrColor, iClear, iClearColor,
    input  data, oWrReady, oBusy, oWrErr
  );

  modport slave (
    input  iCtrH, iCtrV, iWrValid, iWrX, iWrY, iWrColor, iClear, iClearColor,
    output data, oWrReady, oBusy, oWrErr
  );
endinterface
`default_nettype wire

// File: rtl/vga_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : vga_framebuffer
// Description : 80x60-cell, 3-bit RGB framebuffer feeding the VGA timing
//               generator. Each cell covers 8x8 screen pixels. A clear engine
//               fills the buffer after reset or on command; a valid/ready port
//               writes single cells.
// Ports       : clk, rst (sync, active high)
//               bus (slave): iCtrH/iCtrV pixel counters -> data (2-cycle
//               latency, registered); iWrValid/oWrReady/iWrX/iWrY/iWrColor
//               cell write; iClear/iClearColor fill request; oBusy, oWrErr.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_framebuffer #(
  parameter int COLS  = 80,
  parameter int ROWS  = 60,
  parameter int CELLS = COLS * ROWS
) (
  input  logic               clk,
  input  logic               rst,
  vga_framebuffer_if.slave   bus
);

  localparam int             AW          = 13;
  localparam logic [AW-1:0]  c_last_addr = AW'(CELLS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_clr_addr;
  logic [2:0]      r_clr_color;
  logic            r_busy;
  logic            r_ready;
  logic            r_wr_err;

  // Display pipeline: counter sample -> RAM read -> output register
  logic [AW-1:0]   r_samp_addr;
  logic            r_samp_vis;
  logic            r_rd_vis;
  logic [2:0]      r_rd_data;
  logic [2:0]      r_data;

  logic [2:0]      mem [0:CELLS-1];

  logic            w_accept;
  logic            w_in_range;
  logic [AW-1:0]   w_host_addr;
  logic            w_vis;
  logic [AW-1:0]   w_disp_addr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [2:0]      w_wdata;

  assign w_accept    = bus.iWrValid & r_ready;
  assign w_in_range  = (bus.iWrX < 7'(COLS)) && (bus.iWrY < 6'(ROWS));
  assign w_host_addr = AW'(bus.iWrY) * AW'(COLS) + AW'(bus.iWrX);

  // Full-width compares so that huge counter values never alias into the
  // visible area; cell indices then come from plain bit slices.
  assign w_vis       = (bus.iCtrH < 19'(COLS * 8)) && (bus.iCtrV < 19'(ROWS * 8));
  // Invisible pixels read address 0 to keep the read index in range.
  assign w_disp_addr = w_vis ? (AW'(bus.iCtrV[8:3]) * AW'(COLS) + AW'(bus.iCtrH[9:3]))
                             : '0;

  // RAM write port arbitration: the fill engine owns the port while clearing,
  // otherwise an accepted in-range host write uses it.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_host_addr;
    w_wdata = bus.iWrColor;
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        w_wdata = r_clr_color;
      end else if (w_accept && w_in_range) begin
        w_we    = 1'b1;
      end
    end
  end

  // Simple dual-port RAM; the read sees the pre-write contents on a
  // same-address collision.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[w_waddr] <= w_wdata;
    end
    r_rd_data <= mem[r_samp_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_addr <= '0;
      r_samp_vis  <= 1'b0;
      r_rd_vis    <= 1'b0;
      r_data      <= 3'b000;
    end else begin
      r_samp_addr <= w_disp_addr;
      r_samp_vis  <= w_vis;
      r_rd_vis    <= r_samp_vis;
      r_data      <= r_rd_vis ? r_rd_data : 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_clr_color <= 3'b000;
      r_busy      <= 1'b1;
      r_ready     <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (bus.iClear) begin
            r_clr_addr  <= '0;
            r_clr_color <= bus.iClearColor;
            r_wr_err    <= 1'b0;
          end else if (r_clr_addr == c_last_addr) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_clr_addr  <= r_clr_addr + AW'(1);
          end
        end
        S_IDLE: begin
          if (w_accept && !w_in_range) begin
            r_wr_err    <= 1'b1;
          end
          // A write on the same edge has already gone to the RAM port above;
          // the fill simply overwrites it later.
          if (bus.iClear) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_clr_color <= bus.iClearColor;
            r_busy      <= 1'b1;
            r_ready     <= 1'b0;
            r_wr_err    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign bus.data     = r_data;
  assign bus.oWrReady = r_ready;
  assign bus.oBusy    = r_busy;
  assign bus.oWrErr   = r_wr_err;

endmodule
`default_nettype wire

// File: doc/vga_framebuffer.md
# vga_framebuffer

Pixel source for the VGA timing generator. It holds an 80x60 cell framebuffer with 3-bit RGB per cell, where each cell is 8x8 screen pixels. It maps the generator's pixel counters to a colour on the generator's 3-bit `data` input. A write port with a valid/ready handshake updates cells, and a clear engine fills the whole buffer with one colour after reset or on command.

## Interface
- `COLS`, 80: cells per row; column index = iCtrH >> 3.
- `ROWS`, 60: cell rows; row index = iCtrV >> 3.
- `CELLS`, 4800: COLS*ROWS, the framebuffer depth.
- `clk` in 1: single clock. This is the same `clk` that drives the VGA block.
- `rst` in 1: synchronous, active-high reset.
- `iCtrH` in 19: horizontal pixel counter from the VGA block (oCtrH).
- `iCtrV` in 19: vertical line counter from the VGA block (oCtrV).
- `data` out 3: {R,G,B} to the VGA block's `data` input; registered.
- `iWrValid` in 1: write request.
- `oWrReady` out 1: write can be accepted; registered.
- `iWrX` in 7: cell column, 0..79.
- `iWrY` in 6: cell row, 0..59.
- `iWrColor` in 3: colour to write.
- `iClear` in 1: single-cycle request to fill the buffer.
- `iClearColor` in 3: fill colour, sampled with iClear.
- `oBusy` out 1: clear engine active; registered.
- `oWrErr` out 1: sticky flag for an out-of-range write.

## Operation
- Storage is a 4800x3 simple dual-port RAM with a synchronous read port (display) and a write port (host/clear). Address = row*80 + col, 13 bits.
- **Display path**
  - Pixel is visible iff iCtrH < 640 and iCtrV < 480. Otherwise `data` = 3'b000.
  - The visible flag is pipelined alongside the RAM read.
- **FSM**
  - States: CLEAR and IDLE.
  - During reset, the state is forced to CLEAR with clear colour 3'b000, clear address 0, oBusy=1, oWrReady=0, data=0, and oWrErr=0.
  - CLEAR writes the current clear address with the clear colour every cycle, then increments the address. The cycle that writes address 4799 moves to IDLE, sets oBusy=0, and sets oWrReady=1.
  - In IDLE, iClear=1 moves to CLEAR. It latches iClearColor, zeroes the clear address, sets oBusy=1 and oWrReady=0, and clears oWrErr.
  - In CLEAR, iClear=1 restarts the fill from address 0 with the new colour.
- **Writes**
  - A write is accepted on an edge where iWrValid & oWrReady.
  - In range (iWrX<80 and iWrY<60): RAM[iWrY*80+iWrX] <= iWrColor.
  - Out of range: the write is accepted and dropped, and oWrErr is set to 1. oWrErr stays at 1 until reset or iClear.
  - If iWrValid and iClear are both high in IDLE, the write is accepted and performed, then the clear starts on the same edge. The clear later overwrites that write.
  - iWrValid during CLEAR is not accepted. The requester must hold its request until oWrReady=1.
- **Read/write collision:** a display read of an address written on the same edge returns the old value.

## Timing
- **Display latency is 2 clk cycles.** iCtrH/iCtrV are sampled at edge N, the RAM is read at edge N+1, and `data` is valid after edge N+2. The VGA block updates counters every 2 clk, so each counter value is presented for at least 2 cycles.
- A write accepted at edge W is visible to display reads sampled at edge W+1 or later.
- **Clear timing.** If the clear is entered at edge E (the iClear edge, or the last rst=1 edge), fill writes occur at edges E+1..E+4800. oBusy falls and oWrReady rises at edge E+4800. The total is exactly 4800 write cycles.
- Reset mid-clear or mid-write aborts the operation immediately and restarts the fill from address 0.
- Column and row are derived with shifts only; there are no divides. The counters' upper bits are ignored after the range check.

## Test plan
- **Reset fill:** hold rst for 3 cycles, release, then count cycles -> oBusy=1 for exactly 4800 cycles, and oWrReady rises on the same edge oBusy falls. Sweeping counters then shows data=000 everywhere.
- **Single write and latency:** write (x=5, y=2, color=3'b101), then drive iCtrH=40..47 and iCtrV=16..23 -> data=101 exactly 2 cycles after each sample. Neighbouring pixel iCtrH=48 -> 000.
- **Blanking:** after filling with 3'b111, drive iCtrH=640 with iCtrV=0, then iCtrH=0 with iCtrV=480 -> data=000. iCtrH=639 with iCtrV=479 -> 111.
- **Out-of-range write:** write x=80, y=0 -> handshake completes, oWrErr=1, and no cell changes. A subsequent iClear drops oWrErr to 0.
- **Clear restart and backpressure:** iClear with color 010, then iClear with color 100 at the 100th clear cycle -> fill restarts. oBusy lasts 4800 cycles from the second iClear and all cells read 100. A write held valid throughout is accepted exactly on the edge oWrReady=1.
- **Collision:** write cell (0,0)=011 on the same edge its address is read -> that read returns the previous value and the next read returns 011. Write plus iClear in the same cycle -> the cell ends at the clear colour.
